fifo_flags: RTL and testbench
=============================

# fifo_flags

Synchronous single-clock FIFO with registered status flags. It sits directly upstream of the flow-control FSM. It stores 4-bit words and produces the `empty_Fifo`, `no_empty_Fifo`, `almost_full`, `almost_empty` and `Fifo_overflow` indications that the FSM consumes. Almost-full and almost-empty thresholds are loaded at `init`.

## Interface
- `DATA_W`, default 4: word width.
- `ADDR_W`, default 3: address width; depth = 2^ADDR_W = 8.
- `AF_DEF`, default 6: almost-full threshold after reset.
- `AE_DEF`, default 2: almost-empty threshold after reset.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous reset, active-low.
- `init` in 1: load thresholds and clear `Fifo_overflow`.
- `th_almost_full` in ADDR_W+1: almost-full threshold, sampled when `init`=1.
- `th_almost_empty` in ADDR_W+1: almost-empty threshold, sampled when `init`=1.
- `push` in 1: write request.
- `data_in` in DATA_W: write data.
- `pop` in 1: read request.
- `data_Fifo` out DATA_W: registered read data.
- `count` out ADDR_W+1: current occupancy, 0..DEPTH.
- `empty_Fifo` out 1: count == 0.
- `no_empty_Fifo` out 1: count != 0.
- `full` out 1: count == DEPTH.
- `almost_full` out 1: count >= AF threshold.
- `almost_empty` out 1: count <= AE threshold.
- `Fifo_overflow` out 1: sticky; a push occurred while full.

## Operation
- **Reset values (`reset`=0):**
  - Pointers, `count`, `data_Fifo` and `Fifo_overflow` = 0.
  - `empty_Fifo`=1, `no_empty_Fifo`=0, `full`=0, `almost_full`=0, `almost_empty`=1.
  - Thresholds = AF_DEF / AE_DEF.
- **Storage:** circular buffer with wr_ptr/rd_ptr of ADDR_W bits. Pointers wrap DEPTH-1 → 0 naturally. `count` is ADDR_W+1 bits.
- **Push accepted** when `count` < DEPTH, or when `full` and `pop`=1 in the same cycle. Writes `data_in` at wr_ptr, then wr_ptr+1.
- **Pop accepted** when `count` > 0. Register stage: `data_Fifo` ← mem[rd_ptr], then rd_ptr+1.
- **Pop rejected (empty):** pop on empty is ignored. `data_Fifo` holds its value and pointers are unchanged, even if `push`=1 in the same cycle. The push is accepted and `count` becomes 1.
- **Push rejected (full):** `push`=1, `pop`=0, `full`=1. Data is discarded, pointers unchanged, `Fifo_overflow` ← 1.
- **Count update:** count' = count + accepted_push − accepted_pop. Both accepted → count unchanged.
- **Flags:** computed from count' and registered, so they are valid in the same cycle as the new `count`.
- **Threshold comparisons:** unsigned, ADDR_W+1 bits.
  - AF = 0 forces `almost_full`=1.
  - AE ≥ DEPTH forces `almost_empty`=1.
  - No clamping is applied.
- **`init`=1:**
  - Loads both thresholds and clears `Fifo_overflow`.
  - Flags are evaluated against the new thresholds from the next edge onward.
  - FIFO contents, pointers and push/pop behaviour are unaffected.
  - If a rejected push coincides with `init`, `init` wins: `Fifo_overflow`=0.
- **Reset mid-operation:** immediate return to reset values. Contents are lost (memory need not be cleared, but is unreadable until rewritten).

## Timing
- Write-to-read latency: a word pushed at edge N can be popped at edge N+1; it appears on `data_Fifo` after edge N+1.
- Pop latency: 1 cycle. `data_Fifo` is valid after the edge at which `pop` was sampled.
- Flags, `count` and `Fifo_overflow` change only on clock edges; no combinational path from inputs to outputs.
- `Fifo_overflow` rises one cycle after the rejected push is sampled.

## Configuration
- `FIFO_UNDERFLOW_EN`:
  - **Defined:** adds output `Fifo_underflow` (1 bit, reset 0, sticky). It sets on pop with `count`=0 and clears on `init`, with the same priority rule as `Fifo_overflow`.
  - **Undefined:** port absent; pop on empty is silently ignored.

## Structure
- **Package `fifo_pkg`:** default DATA_W, ADDR_W, AF_DEF, AE_DEF, and the derived DEPTH constant, shared with the FSM and its bench.
- **Sub-module `fifo_mem`:** 2^ADDR_W × DATA_W register array with synchronous write port and registered read port.
- **`fifo_flags`:** holds the pointers, count, thresholds and flag logic.

## Test plan
- **Reset, then 8 pushes:**
  - Stimulus: reset released; push 0x1..0x8, one per cycle.
  - Response: `count` 1..8. `almost_full`=1 from count 6. `almost_empty`=0 from count 3. `full`=1 at 8, `Fifo_overflow`=0.
- **Overflow:**
  - Stimulus: push 0xF when full.
  - Response: `count`=8, `Fifo_overflow`=1 next cycle. Subsequent pops return 0x1..0x8 (0xF is absent).
  - Follow-up: `init`=1 clears `Fifo_overflow`.
- **Simultaneous push+pop:**
  - When full: push 0xA with pop. Response: `data_Fifo`=0x1, `count` stays 8, no overflow; 0xA is the last word read.
  - When empty: push with pop. Response: `count`=1, `data_Fifo` unchanged.
- **Pointer wrap:**
  - Stimulus: 20 alternating push/pop pairs of incrementing data.
  - Response: output sequence equals input sequence; `empty_Fifo` toggles correctly across the 7 → 0 wrap.
- **Threshold load:**
  - Stimulus: `init` with AF=3, AE=1; then push 3 words.
  - Response: `almost_full`=1 at count 3, `almost_empty`=0 at count 2.
- **Reset mid-operation:**
  - Stimulus: assert `reset` at count 5 with `Fifo_overflow`=1.
  - Response: outputs return to reset values asynchronously, thresholds revert to 6/2.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and flag bundle, also used by the flow-control FSM.
// Optional FIFO_UNDERFLOW_EN adds a sticky underflow output on fifo_flags.
package fifo_pkg;

  localparam int FIFO_DATA_W = 4;
  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_AF_DEF = 6;
  localparam int FIFO_AE_DEF = 2;
  localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;

  typedef struct packed {
    logic empty;
    logic no_empty;
    logic full;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  localparam flags_t FLAGS_RST = '{
    empty:        1'b1,
    no_empty:     1'b0,
    full:         1'b0,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array, synchronous write, registered read.
// Read returns the pre-write word when both ports hit one address.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_flags.sv
// Single-clock FIFO with registered status flags and loadable thresholds.
// Define FIFO_UNDERFLOW_EN to add the sticky Fifo_underflow output.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int AF_DEF = FIFO_AF_DEF,
  parameter int AE_DEF = FIFO_AE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W:0]   th_almost_full,
  input  logic [ADDR_W:0]   th_almost_empty,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_Fifo,
  output logic [ADDR_W:0]   count,
  output logic              empty_Fifo,
  output logic              no_empty_Fifo,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
`ifdef FIFO_UNDERFLOW_EN
  output logic              Fifo_underflow,
`endif
  output logic              Fifo_overflow
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE =
    (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE =
    (ADDR_W)'(1);
  localparam logic [ADDR_W:0] AF_RST =
    (ADDR_W+1)'(AF_DEF);
  localparam logic [ADDR_W:0] AE_RST =
    (ADDR_W+1)'(AE_DEF);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   af_th;
  logic [ADDR_W:0]   ae_th;
  logic [ADDR_W:0]   count_nxt;
  logic              push_ok;
  logic              pop_ok;
  logic              push_rej;
  flags_t            flg_d;
  flags_t            flg_q;

  // A full FIFO still takes a push when a pop frees a slot.
  always_comb begin
    pop_ok   = pop && (count != '0);
    push_ok  = push && ((count != DEPTH_C) || pop);
    push_rej = push && !push_ok;
  end

  always_comb begin
    count_nxt = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    flg_d              = FLAGS_RST;
    flg_d.empty        = (count_nxt == '0);
    flg_d.no_empty     = (count_nxt != '0);
    flg_d.full         = (count_nxt == DEPTH_C);
    flg_d.almost_full  = (count_nxt >= af_th);
    flg_d.almost_empty = (count_nxt <= ae_th);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      flg_q  <= FLAGS_RST;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      flg_q <= flg_d;
    end
  end

  // New thresholds apply to flags from the edge after init.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      af_th <= AF_RST;
      ae_th <= AE_RST;
    end else if (init) begin
      af_th <= th_almost_full;
      ae_th <= th_almost_empty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Fifo_overflow <= 1'b0;
    end else if (init) begin
      Fifo_overflow <= 1'b0;
    end else if (push_rej) begin
      Fifo_overflow <= 1'b1;
    end
  end

`ifdef FIFO_UNDERFLOW_EN
  logic pop_rej;

  assign pop_rej = pop && (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Fifo_underflow <= 1'b0;
    end else if (init) begin
      Fifo_underflow <= 1'b0;
    end else if (pop_rej) begin
      Fifo_underflow <= 1'b1;
    end
  end
`endif

  assign empty_Fifo    = flg_q.empty;
  assign no_empty_Fifo = flg_q.no_empty;
  assign full          = flg_q.full;
  assign almost_full   = flg_q.almost_full;
  assign almost_empty  = flg_q.almost_empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (data_Fifo)
  );

endmodule

// File: tb/tb_fifo_flags.sv
// Scoreboard bench for fifo_flags: queue-based reference model,
// directed scenarios followed by random push/pop/init traffic.
module tb_fifo_flags;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b0;
  logic [3:0] th_af = 4'd0;
  logic [3:0] th_ae = 4'd0;
  logic       push = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic       pop = 1'b0;
  logic [3:0] data_Fifo;
  logic [3:0] count;
  logic       empty_Fifo;
  logic       no_empty_Fifo;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic       Fifo_overflow;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_flags dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .th_almost_full  (th_af),
    .th_almost_empty (th_ae),
    .push            (push),
    .data_in         (data_in),
    .pop             (pop),
    .data_Fifo       (data_Fifo),
    .count           (count),
    .empty_Fifo      (empty_Fifo),
    .no_empty_Fifo   (no_empty_Fifo),
    .full            (full),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .Fifo_overflow   (Fifo_overflow)
  );

  typedef struct {
    logic [3:0] dout;
    logic [3:0] cnt;
    logic       emp;
    logic       nemp;
    logic       ful;
    logic       af;
    logic       ae;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a plain word queue plus threshold/overflow state.
  logic [3:0] mq[$];
  logic [3:0] m_dout = 4'd0;
  int         m_af = 6;
  int         m_ae = 2;
  logic       m_ovf = 1'b0;

  function automatic exp_t snap();
    exp_t e;
    int n;
    n = mq.size();
    e.dout = m_dout;
    e.cnt  = 4'(n);
    e.emp  = (n == 0);
    e.nemp = (n != 0);
    e.ful  = (n == 8);
    e.af   = (n >= m_af);
    e.ae   = (n <= m_ae);
    e.ovf  = m_ovf;
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin
    exp_t e;
    int   n;
    bit   pa;
    bit   wa;
    if (!reset) begin
      mq.delete();
      m_dout = 4'd0;
      m_af   = 6;
      m_ae   = 2;
      m_ovf  = 1'b0;
      e      = snap();
    end else begin
      n  = mq.size();
      pa = pop && (n > 0);
      wa = push && ((n < 8) || pop);
      if (pa) m_dout = mq.pop_front();
      if (wa) mq.push_back(data_in);
      e = snap();
      if (init) begin
        m_ovf = 1'b0;
        m_af  = int'(th_af);
        m_ae  = int'(th_ae);
      end else if (push && !wa) begin
        m_ovf = 1'b1;
      end
      e.ovf = m_ovf;
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk or negedge reset);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: got no expected entry at %0t",
               $time);
    end else begin
      e = exp_q.pop_front();
      chk("data_Fifo", data_Fifo, e.dout);
      chk("count", count, e.cnt);
      chk("empty_Fifo", {3'b0, empty_Fifo}, {3'b0, e.emp});
      chk("no_empty_Fifo", {3'b0, no_empty_Fifo},
          {3'b0, e.nemp});
      chk("full", {3'b0, full}, {3'b0, e.ful});
      chk("almost_full", {3'b0, almost_full}, {3'b0, e.af});
      chk("almost_empty", {3'b0, almost_empty},
          {3'b0, e.ae});
      chk("Fifo_overflow", {3'b0, Fifo_overflow},
          {3'b0, e.ovf});
    end
  end

  task automatic step(input logic p,
                      input logic [3:0] d,
                      input logic q,
                      input logic i = 1'b0,
                      input logic [3:0] af = 4'd0,
                      input logic [3:0] ae = 4'd0);
    push    = p;
    data_in = d;
    pop     = q;
    init    = i;
    th_af   = af;
    th_ae   = ae;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle();

    for (int k = 1; k <= 8; k++) step(1'b1, 4'(k), 1'b0);
    step(1'b1, 4'hF, 1'b0);
    idle();
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 4'd2);
    step(1'b1, 4'hA, 1'b1);
    for (int k = 0; k < 9; k++) step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'h5, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    idle();

    for (int k = 0; k < 20; k++) begin
      step(1'b1, 4'(k + 3), 1'b0);
      step(1'b0, 4'd0, 1'b1);
    end

    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 4'd1);
    for (int k = 0; k < 3; k++) step(1'b1, 4'(k + 9), 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 4'(k + 1), 1'b0);
    step(1'b1, 4'hE, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 4'd0, 1'b1);

    reset = 1'b0;
    idle();
    reset = 1'b1;
    for (int k = 0; k < 7; k++) step(1'b1, 4'(k + 2), 1'b0);
    for (int k = 0; k < 7; k++) step(1'b0, 4'd0, 1'b1);

    for (int k = 0; k < 600; k++) begin
      logic       p;
      logic       q;
      logic       i;
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 50);
      i = ($urandom_range(0, 99) < 4);
      step(p, 4'($urandom_range(0, 15)), q, i,
           4'($urandom_range(0, 9)),
           4'($urandom_range(0, 9)));
    end

    idle();
    idle();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
